// File: rtl/data_path_if.sv
// Control/status bundle between the iterative machine's control FSM (master)
// and its datapath (slave).
interface data_path_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic [W-1:0]  x;
    logic          active;
    logic          y_en;
    logic          y_store_x;
    logic [1:0]    y_select_next;
    logic          s_en;
    logic          s_zero;
    logic          s_add;
    logic [1:0]    s_step;
    logic [W-1:0]  y;
    logic [W-1:0]  s;
    logic          y_zero;
    logic          y_one;
    logic          y_odd;
    logic          y_ovf;
    logic          s_ovf;
    logic [W-1:0]  result;
    logic [CW-1:0] cycles;
    logic          done;

    modport master (
        output x, active, y_en, y_store_x, y_select_next,
               s_en, s_zero, s_add, s_step,
        input  y, s, y_zero, y_one, y_odd, y_ovf, s_ovf, result, cycles, done
    );

    modport slave (
        input  x, active, y_en, y_store_x, y_select_next,
               s_en, s_zero, s_add, s_step,
        output y, s, y_zero, y_one, y_odd, y_ovf, s_ovf, result, cycles, done
    );
endinterface

// File: rtl/data_path.sv
// Datapath of the iterative machine: working register y, accumulator s,
// sticky overflow flags and end-of-run capture of result and run length.
module data_path #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input logic       clk,
    input logic       rst,
    data_path_if.slave bus
);
    logic [W-1:0]  y_q;
    logic [W-1:0]  s_q;
    logic [W-1:0]  result_q;
    logic [W-1:0]  step;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cycles_q;
    logic          y_ovf_q;
    logic          s_ovf_q;
    logic          active_d;
    logic          done_q;
    logic [W+1:0]  y_triple;
    logic [W:0]    s_sum;

    // Extra headroom bits expose the carry of 3y+1 and s+step for the sticky flags.
    always_comb begin
        step = {{(W-1){1'b0}}, 1'b1};
        case (bus.s_step)
            2'b00: step = {{(W-1){1'b0}}, 1'b1};
            2'b01: step = {{(W-2){1'b0}}, 2'b10};
            2'b10: step = y_q;
            2'b11: step = bus.x;
            default: step = {{(W-1){1'b0}}, 1'b1};
        endcase
        y_triple = {2'b00, y_q} + {1'b0, y_q, 1'b0} + (W+2)'(1);
        s_sum    = {1'b0, s_q} + {1'b0, step};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            y_ovf_q <= 1'b0;
        end else if (bus.y_en) begin
            if (bus.y_store_x) begin
                y_q     <= bus.x;
                y_ovf_q <= 1'b0;
            end else begin
                case (bus.y_select_next)
                    2'b00: y_q <= y_q >> 1;
                    2'b01: y_q <= y_q - W'(1);
                    2'b10: begin
                        y_q <= y_triple[W-1:0];
                        if (y_triple[W+1:W] != 2'b00)
                            y_ovf_q <= 1'b1;
                    end
                    default: y_q <= y_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            s_ovf_q <= 1'b0;
        end else if (bus.s_en) begin
            if (bus.s_zero) begin
                s_q     <= '0;
                s_ovf_q <= 1'b0;
            end else if (bus.s_add) begin
                s_q <= s_sum[W-1:0];
                if (s_sum[W])
                    s_ovf_q <= 1'b1;
            end
        end
    end

    // Falling edge of active closes the run; a reset mid-run clears active_d so no done follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_d <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
        end else begin
            active_d <= bus.active;
            done_q   <= 1'b0;
            if (bus.active) begin
                if (!active_d)
                    cnt <= CW'(1);
                else if (cnt != {CW{1'b1}})
                    cnt <= cnt + CW'(1);
            end else if (active_d) begin
                result_q <= s_q;
                cycles_q <= cnt;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.y      = y_q;
    assign bus.s      = s_q;
    assign bus.y_zero = (y_q == '0);
    assign bus.y_one  = (y_q == W'(1));
    assign bus.y_odd  = y_q[0];
    assign bus.y_ovf  = y_ovf_q;
    assign bus.s_ovf  = s_ovf_q;
    assign bus.result = result_q;
    assign bus.cycles = cycles_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: register arithmetic, sticky flags, async reset
// and end-of-run capture, with hand-computed expectations.
module tb_data_path;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    data_path_if #(.W(8), .CW(16)) bus ();

    data_path #(.W(8), .CW(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one set of strobes for exactly one rising edge, then returns them idle.
    task automatic apply_stimulus(input logic ye, input logic ys, input logic [1:0] sel,
                                  input logic se, input logic sz, input logic sa,
                                  input logic [1:0] st, input logic [7:0] xv);
        bus.y_en          = ye;
        bus.y_store_x     = ys;
        bus.y_select_next = sel;
        bus.s_en          = se;
        bus.s_zero        = sz;
        bus.s_add         = sa;
        bus.s_step        = st;
        bus.x             = xv;
        tick();
        bus.y_en   = 1'b0;
        bus.s_en   = 1'b0;
        bus.s_zero = 1'b0;
        bus.s_add  = 1'b0;
    endtask

    task automatic load_y(input logic [7:0] xv);
        apply_stimulus(1, 1, 2'b11, 0, 0, 0, 2'b00, xv);
    endtask

    task automatic y_op(input logic [1:0] sel);
        apply_stimulus(1, 0, sel, 0, 0, 0, 2'b00, 8'h00);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.active = 1'b0;
        bus.x = '0;
        bus.y_en = 0; bus.y_store_x = 0; bus.y_select_next = 2'b11;
        bus.s_en = 0; bus.s_zero = 0; bus.s_add = 0; bus.s_step = 2'b00;
        #12;
        rst = 1'b0;
        tick();

        // Async reset with non-zero state: 99*3+1 = 298 -> 42 with overflow.
        apply_stimulus(1, 1, 2'b11, 1, 1, 0, 2'b00, 8'd99);
        apply_stimulus(1, 0, 2'b10, 1, 0, 1, 2'b11, 8'h10);
        check_output("pre_rst_y", bus.y, 8'h2A);
        check_output("pre_rst_s", bus.s, 8'h10);
        check_output("pre_rst_yovf", bus.y_ovf, 1);
        #2 rst = 1'b1;
        #1;
        check_output("rst_y", bus.y, 0);
        check_output("rst_s", bus.s, 0);
        check_output("rst_yovf", bus.y_ovf, 0);
        check_output("rst_flags", {bus.y_zero, bus.y_one, bus.y_odd, bus.s_ovf, bus.done}, 5'b10000);
        check_output("rst_result", bus.result, 0);
        check_output("rst_cycles", bus.cycles, 0);
        rst = 1'b0;
        tick();

        // Load and iterate.
        load_y(8'd27);
        check_output("load27_y", bus.y, 27);
        check_output("load27_odd", bus.y_odd, 1);
        y_op(2'b10);
        check_output("triple_y", bus.y, 82);
        y_op(2'b00);
        check_output("shift_y", bus.y, 41);
        y_op(2'b01);
        check_output("dec_y", bus.y, 40);
        y_op(2'b11);
        check_output("hold_y", bus.y, 40);
        check_output("iter_yovf", bus.y_ovf, 0);

        // Flags at 1, 0 and the silent wrap from 0.
        load_y(8'd1);
        check_output("one_flags", {bus.y_zero, bus.y_one, bus.y_odd}, 3'b011);
        y_op(2'b01);
        check_output("zero_flags", {bus.y_zero, bus.y_one, bus.y_odd}, 3'b100);
        y_op(2'b01);
        check_output("wrap_y", bus.y, 8'hFF);
        check_output("wrap_yovf", bus.y_ovf, 0);

        // y overflow is sticky until a store.
        load_y(8'd100);
        y_op(2'b10);
        check_output("ovf_y", bus.y, 45);
        check_output("ovf_flag", bus.y_ovf, 1);
        y_op(2'b00);
        check_output("ovf_shift_y", bus.y, 22);
        check_output("ovf_sticky", bus.y_ovf, 1);
        load_y(8'd5);
        check_output("ovf_clr_y", bus.y, 5);
        check_output("ovf_clr", bus.y_ovf, 0);
        apply_stimulus(0, 0, 2'b10, 0, 0, 0, 2'b00, 8'h00);
        check_output("y_en_low_hold", bus.y, 5);

        // s arithmetic.
        apply_stimulus(0, 0, 2'b11, 1, 1, 0, 2'b00, 8'h00);
        check_output("s_zero", bus.s, 0);
        load_y(8'd200);
        apply_stimulus(0, 0, 2'b11, 1, 0, 1, 2'b10, 8'h00);
        check_output("s_add_y1", bus.s, 200);
        check_output("s_add_y1_ovf", bus.s_ovf, 0);
        apply_stimulus(0, 0, 2'b11, 1, 0, 1, 2'b10, 8'h00);
        check_output("s_add_y2", bus.s, 144);
        check_output("s_add_y2_ovf", bus.s_ovf, 1);
        apply_stimulus(0, 0, 2'b11, 1, 1, 1, 2'b10, 8'h00);
        check_output("s_zero_prio", bus.s, 0);
        check_output("s_zero_prio_ovf", bus.s_ovf, 0);
        apply_stimulus(0, 0, 2'b11, 0, 0, 1, 2'b00, 8'h00);
        check_output("s_en_low_hold", bus.s, 0);
        apply_stimulus(0, 0, 2'b11, 1, 0, 1, 2'b00, 8'h00);
        check_output("s_step1", bus.s, 1);
        apply_stimulus(0, 0, 2'b11, 1, 0, 1, 2'b01, 8'h00);
        check_output("s_step2", bus.s, 3);
        apply_stimulus(1, 1, 2'b11, 1, 0, 1, 2'b10, 8'd7);
        check_output("s_pre_edge_y", bus.s, 203);
        check_output("y_same_edge", bus.y, 7);
        apply_stimulus(0, 0, 2'b11, 1, 0, 1, 2'b11, 8'd7);
        check_output("s_step_x", bus.s, 210);

        // Run capture with s = 0x33.
        apply_stimulus(0, 0, 2'b11, 1, 1, 0, 2'b00, 8'h00);
        apply_stimulus(0, 0, 2'b11, 1, 0, 1, 2'b11, 8'h33);
        bus.active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("run5_done_low%0d", i), bus.done, 0);
        end
        bus.active = 1'b0;
        tick();
        check_output("run5_done", bus.done, 1);
        check_output("run5_cycles", bus.cycles, 5);
        check_output("run5_result", bus.result, 8'h33);
        tick();
        check_output("run5_done_once", bus.done, 0);
        check_output("run5_cycles_hold", bus.cycles, 5);

        bus.active = 1'b1;
        tick();
        tick();
        bus.active = 1'b0;
        tick();
        check_output("run2_done", bus.done, 1);
        check_output("run2_cycles", bus.cycles, 2);

        // Immediate re-assert after the fall: done still pulses, count restarts.
        bus.active = 1'b1;
        tick();
        tick();
        tick();
        bus.active = 1'b0;
        tick();
        check_output("run3_done", bus.done, 1);
        check_output("run3_cycles", bus.cycles, 3);
        bus.active = 1'b1;
        tick();
        check_output("restart_done_low", bus.done, 0);
        tick();
        bus.active = 1'b0;
        tick();
        check_output("restart_done", bus.done, 1);
        check_output("restart_cycles", bus.cycles, 2);
        tick();

        // Abort: reset during a run yields no done and clears captures.
        bus.active = 1'b1;
        tick();
        tick();
        tick();
        bus.active = 1'b0;
        rst = 1'b1;
        #3;
        check_output("abort_done_rst", bus.done, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("abort_done%0d", i), bus.done, 0);
        end
        check_output("abort_result", bus.result, 0);
        check_output("abort_cycles", bus.cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
